axi4_slave_burst_mem: RTL and testbench
=======================================

// Module: axi4_slave_burst_mem
// PURPOSE
//  AXI4 slave endpoint consuming the transactions issued by the AXI4 master BFM and the PS master port.
//  Accepts FIXED/INCR bursts on independent write and read channels.
//  Maps them onto a simple dual-port word RAM interface (frame/register buffer) on the same clock.
//  Write and read FSMs run concurrently; no arbitration (separate RAM ports).
// PARAMETERS
//  C_S_AXI_ADDR_WIDTH  32  AXI address width (AxADDR)
//  C_S_AXI_DATA_WIDTH  32  AXI data width; only 32 supported
//  C_MEM_ADDR_WIDTH    10  RAM word-address width; mem addr = AxADDR[C_MEM_ADDR_WIDTH+1:2]
// PORTS
//  ACLK     in   1  clock, all logic on rising edge
//  ARESETN  in   1  asynchronous active-low reset
//  S_AXI_AW{ID,ADDR,LEN,SIZE,BURST}  in   1/32/8/3/2  write address fields
//  S_AXI_AWVALID / S_AXI_AWREADY     in/out  1  AW handshake
//  S_AXI_W{DATA,STRB,LAST}           in   32/4/1  write data beat
//  S_AXI_WVALID / S_AXI_WREADY       in/out  1  W handshake
//  S_AXI_B{ID,RESP,USER}             out  1/2/1  write response; BUSER tied 0
//  S_AXI_BVALID / S_AXI_BREADY       out/in  1  B handshake
//  S_AXI_AR{ID,ADDR,LEN,SIZE,BURST}  in   1/32/8/3/2  read address fields
//  S_AXI_ARVALID / S_AXI_ARREADY     in/out  1  AR handshake
//  S_AXI_R{ID,DATA,RESP,LAST,USER}   out  1/32/2/1/1  read beat; RUSER tied 0
//  S_AXI_RVALID / S_AXI_RREADY       out/in  1  R handshake
//  mem_we, mem_waddr, mem_wdata, mem_wstrb  out  1/C_MEM_ADDR_WIDTH/32/4  RAM write port
//  mem_re, mem_raddr                 out  1/C_MEM_ADDR_WIDTH  RAM read request
//  mem_rdata                         in   32  RAM read data, valid 1 cycle after mem_re
// BEHAVIOUR
//  Reset: AWREADY=1, ARREADY=1; WREADY, BVALID, RVALID, RLAST, mem_we, mem_re = 0.
//   All data/addr/ID/RESP outputs = 0. Both FSMs go to IDLE immediately (async).
//  Reset mid-burst: the transaction is dropped; no B/R is issued for it after ARESETN rises.
//  Write FSM WR_IDLE -> WR_DATA -> WR_RESP -> WR_IDLE:
//   WR_IDLE: AWREADY=1. On AWVALID&AWREADY, latch ID, addr, LEN, SIZE, BURST; beat_cnt=0.
//     err = (AWSIZE!=3'b010) | (AWBURST not FIXED/INCR). AWREADY=0 next cycle.
//   WR_DATA: WREADY=1. Each WVALID&WREADY (same cycle, combinational):
//     mem_we=~err, mem_waddr=cur addr, mem_wdata=WDATA, mem_wstrb=WSTRB.
//     Then cur addr += 1 word (INCR) or holds (FIXED); beat_cnt++.
//   Last beat = WLAST | (beat_cnt==LEN). On it go to WR_RESP with WREADY=0.
//     err |= (WLAST != (beat_cnt==LEN)), i.e. early or missing WLAST -> SLVERR.
//   WR_RESP: BVALID=1, BID=latched ID, BRESP=err?2'b10:2'b00.
//     Hold until BREADY; next cycle WR_IDLE, AWREADY=1.
//  AWVALID may precede, coincide with, or follow first WVALID. W beats are not accepted before AW (WREADY=0 in IDLE).
//  Read FSM RD_IDLE -> RD_FETCH -> RD_DATA -> (RD_FETCH | RD_IDLE):
//   RD_IDLE: ARREADY=1. On handshake, latch fields, beat_cnt=0. err rule same as write.
//   RD_FETCH: mem_re=~err for exactly 1 cycle, mem_raddr=cur addr.
//   RD_DATA: RVALID=1; RDATA=err?0:mem_rdata (registered at entry, stable while stalled).
//     RID=latched ID, RRESP per err, RLAST=(beat_cnt==LEN).
//     On RVALID&RREADY: RLAST -> RD_IDLE, else advance addr/beat_cnt -> RD_FETCH.
//   Throughput: 1 read beat / 2 cycles; latency AR handshake -> first RVALID = 2 cycles.
//  Address wrap: cur addr is C_MEM_ADDR_WIDTH bits and wraps modulo RAM size. No 4KB check.
//  AxLEN 0..255 supported (1..256 beats); beat_cnt 8 bits.
//  VALID outputs never deasserted before the handshake; payload stable while VALID & ~READY.
// STRUCTURE
//  axi_defs.vh (shared `define include): BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR, SIZE_4B.
//   Also write/read FSM state encodings.
//  Sub-module axi4_slave_rd_fsm: read channel (AR/R + mem_re). Write channel stays in top.
// TESTING (bench drives via AXI4 master BFM tasks, RAM model 1-cycle latency)
//  1 INCR write id0 addr 0x100 len 3 data 0x11..0x14 wmax_wait 0.
//    -> RAM words 0x40..0x43 = 0x11..0x14; BRESP=00, BID=0.
//  2 INCR read id1 addr 0x100 len 3 rmax_wait 3 (RREADY stalls).
//    -> RDATA 0x11..0x14 in order, RLAST on 4th beat only, RID=1, RRESP=00.
//  3 FIXED write addr 0x20 len 2 data 0xA0..0xA2.
//    -> RAM word 0x08 = 0xA2, neighbours unchanged, BRESP=00.
//  4 AWBURST=WRAP or AWSIZE=1 len 1.
//    -> 2 beats accepted, mem_we never 1, BRESP=10. Read equivalent -> RDATA=0, RRESP=10 each beat.
//  5 Write len 3 with WLAST on beat 2 -> BRESP=10 after beat 2, FSM back to IDLE, next write OK.
//  6 Concurrent write + read; BREADY delayed 5 clks; ARESETN pulsed low mid-read burst.
//    -> all outputs return to reset values; no stray RVALID after release.

Source files
------------

// File: rtl/axi4_slave_burst_mem_pkg.sv
// Shared constants, FSM state types and the burst-legality helper for the
// AXI4 burst-to-RAM slave.
package axi4_slave_burst_mem_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] SIZE_4B     = 3'b010;

    typedef enum logic [1:0] {
        WR_IDLE = 2'b00,
        WR_DATA = 2'b01,
        WR_RESP = 2'b10
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'b00,
        RD_FETCH = 2'b01,
        RD_DATA  = 2'b10
    } rd_state_t;

    // Only full-word FIXED/INCR bursts are serviced; anything else completes with SLVERR.
    function automatic logic cfg_err(input logic [2:0] size, input logic [1:0] burst);
        return (size != SIZE_4B) || ((burst != BURST_FIXED) && (burst != BURST_INCR));
    endfunction

endpackage

// File: rtl/axi4_slave_burst_mem_rd_fsm.sv
// Read channel: accepts AR, issues one RAM read per beat and returns R beats
// (one beat every two cycles).
module axi4_slave_rd_fsm
    import axi4_slave_burst_mem_pkg::*;
#(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int MEM_AW = 10
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_arid,
    input  logic [AW-1:0]     i_araddr,
    input  logic [7:0]        i_arlen,
    input  logic [2:0]        i_arsize,
    input  logic [1:0]        i_arburst,
    input  logic              i_arvalid,
    output logic              o_arready,
    output logic              o_rid,
    output logic [DW-1:0]     o_rdata,
    output logic [1:0]        o_rresp,
    output logic              o_rlast,
    output logic              o_rvalid,
    input  logic              i_rready,
    output logic              o_mem_re,
    output logic [MEM_AW-1:0] o_mem_raddr,
    input  logic [DW-1:0]     i_mem_rdata
);

    localparam logic [MEM_AW-1:0] ADDR_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

    rd_state_t         r_state;
    rd_state_t         w_state_nxt;
    logic              r_id;
    logic              r_err;
    logic              r_fixed;
    logic              r_first;
    logic [7:0]        r_len;
    logic [7:0]        r_beat;
    logic [MEM_AW-1:0] r_addr;
    logic [DW-1:0]     r_hold;
    logic              w_ar_fire;
    logic              w_r_fire;
    logic              w_last;
    logic [DW-1:0]     w_rdata;
    logic              w_unused;

    assign w_ar_fire = (r_state == RD_IDLE) && i_arvalid;
    assign w_r_fire  = (r_state == RD_DATA) && i_rready;
    assign w_last    = (r_beat == r_len);
    assign w_rdata   = r_err ? {DW{1'b0}} : i_mem_rdata;
    assign w_unused  = ^{i_araddr[AW-1:MEM_AW+2], i_araddr[1:0]};

    // Next-state decode for the read channel.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RD_IDLE: begin
                if (i_arvalid) w_state_nxt = RD_FETCH;
                else           w_state_nxt = RD_IDLE;
            end
            RD_FETCH: w_state_nxt = RD_DATA;
            RD_DATA: begin
                if (i_rready) w_state_nxt = w_last ? RD_IDLE : RD_FETCH;
                else          w_state_nxt = RD_DATA;
            end
            default: w_state_nxt = RD_IDLE;
        endcase
    end

    // Read state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RD_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Burst bookkeeping and hold register for stalled R beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id    <= 1'b0;
            r_err   <= 1'b0;
            r_fixed <= 1'b0;
            r_first <= 1'b0;
            r_len   <= 8'd0;
            r_beat  <= 8'd0;
            r_addr  <= {MEM_AW{1'b0}};
            r_hold  <= {DW{1'b0}};
        end else begin
            if (w_ar_fire) begin
                r_id    <= i_arid;
                r_len   <= i_arlen;
                r_beat  <= 8'd0;
                r_addr  <= i_araddr[MEM_AW+1:2];
                r_err   <= cfg_err(i_arsize, i_arburst);
                r_fixed <= (i_arburst == BURST_FIXED);
            end else if (w_r_fire && !w_last) begin
                r_beat <= r_beat + 8'd1;
                if (!r_fixed) r_addr <= r_addr + ADDR_ONE;
            end
            r_first <= (r_state == RD_FETCH);
            // RAM data is only guaranteed on the first DATA cycle; keep it for stalls.
            if ((r_state == RD_DATA) && r_first) r_hold <= w_rdata;
        end
    end

    assign o_arready   = (r_state == RD_IDLE);
    assign o_rvalid    = (r_state == RD_DATA);
    assign o_rid       = r_id;
    assign o_rlast     = o_rvalid && w_last;
    assign o_rresp     = (o_rvalid && r_err) ? RESP_SLVERR : RESP_OKAY;
    assign o_rdata     = !o_rvalid ? {DW{1'b0}} : (r_first ? w_rdata : r_hold);
    assign o_mem_re    = (r_state == RD_FETCH) && !r_err;
    assign o_mem_raddr = (r_state == RD_FETCH) ? r_addr : {MEM_AW{1'b0}};

endmodule

// File: rtl/axi4_slave_burst_mem.sv
// AXI4 slave mapping FIXED/INCR bursts onto a dual-port word RAM; the write
// channel lives here, the read channel in axi4_slave_rd_fsm.
module axi4_slave_burst_mem
    import axi4_slave_burst_mem_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_MEM_ADDR_WIDTH   = 10
)(
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic                            S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BUSER,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic                            S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic                            S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RUSER,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            mem_we,
    output logic [C_MEM_ADDR_WIDTH-1:0]     mem_waddr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   mem_wdata,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0] mem_wstrb,
    output logic                            mem_re,
    output logic [C_MEM_ADDR_WIDTH-1:0]     mem_raddr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   mem_rdata
);

    localparam int                          SW       = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [C_MEM_ADDR_WIDTH-1:0] ADDR_ONE = {{(C_MEM_ADDR_WIDTH-1){1'b0}}, 1'b1};

    wr_state_t                   r_wr_state;
    wr_state_t                   w_wr_state_nxt;
    logic                        r_wr_id;
    logic                        r_wr_err;
    logic                        r_wr_fixed;
    logic [7:0]                  r_wr_len;
    logic [7:0]                  r_wr_beat;
    logic [C_MEM_ADDR_WIDTH-1:0] r_wr_addr;
    logic                        w_aw_fire;
    logic                        w_w_fire;
    logic                        w_len_hit;
    logic                        w_w_last;
    logic                        w_unused;

    assign w_aw_fire = (r_wr_state == WR_IDLE) && S_AXI_AWVALID;
    assign w_w_fire  = (r_wr_state == WR_DATA) && S_AXI_WVALID;
    assign w_len_hit = (r_wr_beat == r_wr_len);
    // A burst ends on whichever comes first: WLAST or the AWLEN count.
    assign w_w_last  = S_AXI_WLAST || w_len_hit;
    assign w_unused  = ^{S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:C_MEM_ADDR_WIDTH+2], S_AXI_AWADDR[1:0]};

    // Next-state decode for the write channel.
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        case (r_wr_state)
            WR_IDLE: begin
                if (S_AXI_AWVALID) w_wr_state_nxt = WR_DATA;
                else               w_wr_state_nxt = WR_IDLE;
            end
            WR_DATA: begin
                if (w_w_fire && w_w_last) w_wr_state_nxt = WR_RESP;
                else                      w_wr_state_nxt = WR_DATA;
            end
            WR_RESP: begin
                if (S_AXI_BREADY) w_wr_state_nxt = WR_IDLE;
                else              w_wr_state_nxt = WR_RESP;
            end
            default: w_wr_state_nxt = WR_IDLE;
        endcase
    end

    // Write state register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) r_wr_state <= WR_IDLE;
        else          r_wr_state <= w_wr_state_nxt;
    end

    // Write burst bookkeeping: latched AW fields, beat counter, running address, error.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wr_id    <= 1'b0;
            r_wr_err   <= 1'b0;
            r_wr_fixed <= 1'b0;
            r_wr_len   <= 8'd0;
            r_wr_beat  <= 8'd0;
            r_wr_addr  <= {C_MEM_ADDR_WIDTH{1'b0}};
        end else if (w_aw_fire) begin
            r_wr_id    <= S_AXI_AWID;
            r_wr_len   <= S_AXI_AWLEN;
            r_wr_beat  <= 8'd0;
            r_wr_addr  <= S_AXI_AWADDR[C_MEM_ADDR_WIDTH+1:2];
            r_wr_err   <= cfg_err(S_AXI_AWSIZE, S_AXI_AWBURST);
            r_wr_fixed <= (S_AXI_AWBURST == BURST_FIXED);
        end else if (w_w_fire) begin
            r_wr_beat <= r_wr_beat + 8'd1;
            if (!r_wr_fixed) r_wr_addr <= r_wr_addr + ADDR_ONE;
            if (w_w_last) r_wr_err <= r_wr_err || (S_AXI_WLAST != w_len_hit);
        end
    end

    assign S_AXI_AWREADY = (r_wr_state == WR_IDLE);
    assign S_AXI_WREADY  = (r_wr_state == WR_DATA);
    assign S_AXI_BVALID  = (r_wr_state == WR_RESP);
    assign S_AXI_BID     = r_wr_id;
    assign S_AXI_BRESP   = (S_AXI_BVALID && r_wr_err) ? RESP_SLVERR : RESP_OKAY;
    assign S_AXI_BUSER   = 1'b0;

    assign mem_we    = w_w_fire && !r_wr_err;
    assign mem_waddr = w_w_fire ? r_wr_addr   : {C_MEM_ADDR_WIDTH{1'b0}};
    assign mem_wdata = w_w_fire ? S_AXI_WDATA : {C_S_AXI_DATA_WIDTH{1'b0}};
    assign mem_wstrb = w_w_fire ? S_AXI_WSTRB : {SW{1'b0}};

    assign S_AXI_RUSER = 1'b0;

    axi4_slave_rd_fsm #(
        .AW     (C_S_AXI_ADDR_WIDTH),
        .DW     (C_S_AXI_DATA_WIDTH),
        .MEM_AW (C_MEM_ADDR_WIDTH)
    ) u_rd_fsm (
        .clk         (ACLK),
        .rst_n       (ARESETN),
        .i_arid      (S_AXI_ARID),
        .i_araddr    (S_AXI_ARADDR),
        .i_arlen     (S_AXI_ARLEN),
        .i_arsize    (S_AXI_ARSIZE),
        .i_arburst   (S_AXI_ARBURST),
        .i_arvalid   (S_AXI_ARVALID),
        .o_arready   (S_AXI_ARREADY),
        .o_rid       (S_AXI_RID),
        .o_rdata     (S_AXI_RDATA),
        .o_rresp     (S_AXI_RRESP),
        .o_rlast     (S_AXI_RLAST),
        .o_rvalid    (S_AXI_RVALID),
        .i_rready    (S_AXI_RREADY),
        .o_mem_re    (mem_re),
        .o_mem_raddr (mem_raddr),
        .i_mem_rdata (mem_rdata)
    );

endmodule

// File: tb/tb_axi4_slave_burst_mem.sv
// Directed bench for axi4_slave_burst_mem: master-side tasks plus a
// one-cycle-latency RAM model; expected values are hand-computed constants.
module tb_axi4_slave_burst_mem;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        S_AXI_AWID, S_AXI_AWVALID, S_AXI_AWREADY;
    logic [31:0] S_AXI_AWADDR;
    logic [7:0]  S_AXI_AWLEN;
    logic [2:0]  S_AXI_AWSIZE;
    logic [1:0]  S_AXI_AWBURST;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
    logic        S_AXI_BID, S_AXI_BUSER, S_AXI_BVALID, S_AXI_BREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_ARID, S_AXI_ARVALID, S_AXI_ARREADY;
    logic [31:0] S_AXI_ARADDR;
    logic [7:0]  S_AXI_ARLEN;
    logic [2:0]  S_AXI_ARSIZE;
    logic [1:0]  S_AXI_ARBURST;
    logic        S_AXI_RID, S_AXI_RLAST, S_AXI_RUSER, S_AXI_RVALID, S_AXI_RREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        mem_we, mem_re;
    logic [9:0]  mem_waddr, mem_raddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = 32'h0;

    bit   [31:0] tb_mem [0:1023];
    int          n_checks = 0;
    int          n_errors = 0;
    int          lat;
    int          stray;

    always #5 ACLK = ~ACLK;

    axi4_slave_burst_mem dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BUSER(S_AXI_BUSER),
        .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RUSER(S_AXI_RUSER),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    // RAM model: byte-strobed write port, registered read data one cycle after mem_re.
    always @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) tb_mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        if (mem_re) mem_rdata <= tb_mem[mem_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input logic [31:0] d0, input int nbeats, input int last_beat,
                             input int bdelay, input logic [1:0] exp_resp,
                             input logic exp_we, input string tag);
        int t;
        logic [9:0] exp_addr;
        @(negedge ACLK);
        S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = len;
        S_AXI_AWSIZE = size; S_AXI_AWBURST = burst; S_AXI_AWVALID = 1'b1;
        #1;
        t = 0;
        while (!S_AXI_AWREADY && t < 50) begin @(negedge ACLK); #1; t++; end
        chk({tag, "_awready"}, S_AXI_AWREADY, 1'b1);
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            S_AXI_WDATA = d0 + i; S_AXI_WSTRB = 4'hF;
            S_AXI_WLAST = (i == last_beat); S_AXI_WVALID = 1'b1;
            #1;
            t = 0;
            while (!S_AXI_WREADY && t < 50) begin @(negedge ACLK); #1; t++; end
            chk({tag, "_wready"}, S_AXI_WREADY, 1'b1);
            chk({tag, "_we"}, mem_we, exp_we);
            if (exp_we) begin
                exp_addr = 10'(addr >> 2) + ((burst == 2'b01) ? 10'(i) : 10'd0);
                chk({tag, "_waddr"}, mem_waddr, exp_addr);
            end
            @(negedge ACLK);
            S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
        end
        #1;
        t = 0;
        while (!S_AXI_BVALID && t < 50) begin @(negedge ACLK); #1; t++; end
        chk({tag, "_bvalid"}, S_AXI_BVALID, 1'b1);
        for (int k = 0; k < bdelay; k++) begin
            @(negedge ACLK); #1;
            chk({tag, "_bhold"}, S_AXI_BVALID, 1'b1);
        end
        chk({tag, "_bresp"}, S_AXI_BRESP, exp_resp);
        chk({tag, "_bid"}, S_AXI_BID, id);
        S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [31:0] d0, input logic [31:0] step, input int stall_mod,
                            input logic [1:0] exp_resp, input string tag, output int lat_o);
        int t;
        @(negedge ACLK);
        S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = len;
        S_AXI_ARSIZE = size; S_AXI_ARBURST = burst; S_AXI_ARVALID = 1'b1;
        #1;
        t = 0;
        while (!S_AXI_ARREADY && t < 50) begin @(negedge ACLK); #1; t++; end
        chk({tag, "_arready"}, S_AXI_ARREADY, 1'b1);
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        #1;
        lat_o = 1;
        for (int i = 0; i <= int'(len); i++) begin
            t = 0;
            while (!S_AXI_RVALID && t < 50) begin
                @(negedge ACLK); #1; t++;
                if (i == 0) lat_o++;
            end
            chk({tag, "_rvalid"}, S_AXI_RVALID, 1'b1);
            for (int s = 0; s < (i % (stall_mod + 1)); s++) begin
                @(negedge ACLK); #1;
            end
            chk({tag, "_rdata"}, S_AXI_RDATA, d0 + step * i);
            chk({tag, "_rlast"}, S_AXI_RLAST, (i == int'(len)));
            chk({tag, "_rid"}, S_AXI_RID, id);
            chk({tag, "_rresp"}, S_AXI_RRESP, exp_resp);
            S_AXI_RREADY = 1'b1;
            @(negedge ACLK);
            S_AXI_RREADY = 1'b0;
            #1;
        end
    endtask

    initial begin
        ARESETN = 1'b0;
        S_AXI_AWID = 1'b0; S_AXI_AWADDR = 32'h0; S_AXI_AWLEN = 8'h0; S_AXI_AWSIZE = 3'h0;
        S_AXI_AWBURST = 2'h0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'h0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARID = 1'b0; S_AXI_ARADDR = 32'h0; S_AXI_ARLEN = 8'h0; S_AXI_ARSIZE = 3'h0;
        S_AXI_ARBURST = 2'h0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        repeat (3) @(negedge ACLK);
        #1;
        chk("rst_awready", S_AXI_AWREADY, 1'b1);
        chk("rst_arready", S_AXI_ARREADY, 1'b1);
        chk("rst_wready",  S_AXI_WREADY,  1'b0);
        chk("rst_bvalid",  S_AXI_BVALID,  1'b0);
        chk("rst_rvalid",  S_AXI_RVALID,  1'b0);
        chk("rst_rlast",   S_AXI_RLAST,   1'b0);
        chk("rst_mem_we",  mem_we,        1'b0);
        chk("rst_mem_re",  mem_re,        1'b0);
        @(negedge ACLK);
        ARESETN = 1'b1;

        // 1: INCR write of four words at 0x100
        axi_write(1'b0, 32'h100, 8'd3, 3'b010, 2'b01, 32'h11, 4, 3, 0, 2'b00, 1'b1, "t1");
        for (int i = 0; i < 4; i++) chk("t1_ram", tb_mem[10'h40 + i], 32'h11 + i);

        // 2: INCR read back with RREADY stalls, latency 2 to first RVALID
        axi_read(1'b1, 32'h100, 8'd3, 3'b010, 2'b01, 32'h11, 32'd1, 3, 2'b00, "t2", lat);
        chk("t2_lat", lat, 32'd2);

        // 3: FIXED write keeps hitting word 0x08
        axi_write(1'b0, 32'h20, 8'd2, 3'b010, 2'b00, 32'hA0, 3, 2, 0, 2'b00, 1'b1, "t3");
        chk("t3_ram8", tb_mem[10'h08], 32'hA2);
        chk("t3_ram7", tb_mem[10'h07], 32'h0);
        chk("t3_ram9", tb_mem[10'h09], 32'h0);

        // 4: illegal burst type / size -> no RAM writes, SLVERR, zero read data
        axi_write(1'b1, 32'h200, 8'd1, 3'b010, 2'b10, 32'h55, 2, 1, 0, 2'b10, 1'b0, "t4w");
        axi_write(1'b0, 32'h204, 8'd1, 3'b001, 2'b01, 32'h65, 2, 1, 0, 2'b10, 1'b0, "t4s");
        chk("t4_ram80", tb_mem[10'h80], 32'h0);
        chk("t4_ram81", tb_mem[10'h81], 32'h0);
        axi_read(1'b0, 32'h100, 8'd1, 3'b010, 2'b10, 32'h0, 32'd0, 0, 2'b10, "t4r", lat);

        // 5: early WLAST on the second beat of a 4-beat burst, then a clean write
        axi_write(1'b0, 32'h280, 8'd3, 3'b010, 2'b01, 32'h30, 2, 1, 0, 2'b10, 1'b1, "t5e");
        axi_write(1'b1, 32'h300, 8'd0, 3'b010, 2'b01, 32'h77, 1, 0, 0, 2'b00, 1'b1, "t5ok");
        chk("t5_ram", tb_mem[10'hC0], 32'h77);

        // 6a: concurrent write (BREADY held off 5 clocks) and read
        fork
            axi_write(1'b1, 32'h400, 8'd3, 3'b010, 2'b01, 32'h200, 4, 3, 5, 2'b00, 1'b1, "t6w");
            axi_read(1'b0, 32'h100, 8'd3, 3'b010, 2'b01, 32'h11, 32'd1, 1, 2'b00, "t6r", lat);
        join
        chk("t6_ram", tb_mem[10'h103], 32'h203);

        // 6b: reset in the middle of a read burst with a write burst open
        @(negedge ACLK);
        S_AXI_AWID = 1'b1; S_AXI_AWADDR = 32'h500; S_AXI_AWLEN = 8'd3;
        S_AXI_AWSIZE = 3'b010; S_AXI_AWBURST = 2'b01; S_AXI_AWVALID = 1'b1;
        S_AXI_ARID = 1'b1; S_AXI_ARADDR = 32'h100; S_AXI_ARLEN = 8'd7;
        S_AXI_ARSIZE = 3'b010; S_AXI_ARBURST = 2'b01; S_AXI_ARVALID = 1'b1;
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        @(negedge ACLK); #1;
        chk("t6b_rvalid0", S_AXI_RVALID, 1'b1);
        S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_RREADY = 1'b0;
        @(negedge ACLK); #1;
        chk("t6b_rvalid1", S_AXI_RVALID, 1'b1);
        ARESETN = 1'b0;
        #1;
        chk("t6b_awready", S_AXI_AWREADY, 1'b1);
        chk("t6b_arready", S_AXI_ARREADY, 1'b1);
        chk("t6b_wready",  S_AXI_WREADY,  1'b0);
        chk("t6b_bvalid",  S_AXI_BVALID,  1'b0);
        chk("t6b_rvalid",  S_AXI_RVALID,  1'b0);
        chk("t6b_rlast",   S_AXI_RLAST,   1'b0);
        chk("t6b_rdata",   S_AXI_RDATA,   32'h0);
        chk("t6b_rid",     S_AXI_RID,     1'b0);
        chk("t6b_bid",     S_AXI_BID,     1'b0);
        chk("t6b_mem_re",  mem_re,        1'b0);
        @(negedge ACLK);
        ARESETN = 1'b1; S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
        stray = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge ACLK); #1;
            if (S_AXI_RVALID || S_AXI_BVALID) stray++;
        end
        chk("t6b_stray", stray, 32'd0);
        S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
        axi_read(1'b1, 32'h104, 8'd1, 3'b010, 2'b01, 32'h12, 32'd1, 0, 2'b00, "t6c", lat);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
